// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit: operand width,
// mul/div op encodings and the control FSM state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX
  } md_state_t;

  // Only the four arithmetic ops take the multi-cycle path.
  function automatic logic is_muldiv_op(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute-stage request/response bundle between the pipeline (master) and
// the HI/LO multiply/divide unit (slave).
interface hilo_muldiv_if #(parameter int XLEN = 32);

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step per enable on unsigned magnitudes: shift-add multiply or
// restoring divide, sharing a single add/subtract on the accumulator top half.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   b_q;
  logic [XLEN:0]     x;
  logic [XLEN:0]     y;
  logic              sub;
  logic [XLEN+1:0]   sum;

  // Divide works on the partial remainder shifted left by one; multiply
  // adds the multiplicand to the top half. Sum MSB is "no borrow" when dividing.
  always_comb begin
    sub = is_div;
    y   = {1'b0, b_q};
    if (is_div) begin
      x = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    end else begin
      x = {1'b0, acc_q[2*XLEN-1:XLEN]};
    end
    sum = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{(XLEN+1){1'b0}}, sub};

    if (is_div) begin
      if (sum[XLEN+1]) begin
        acc_d = {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {x[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_d = {sum[XLEN:0], acc_q[XLEN-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, a_mag};
      b_q   <= b_mag;
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO,
// with sign handling around an unsigned iteration core.
module hilo_muldiv #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int ITER = XLEN
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(ITER);

  md_state_t         state_q;
  md_state_t         state_d;
  logic [CNT_W-1:0]  cnt_q;
  md_op_t            op_q;
  logic [XLEN-1:0]   rs_q;
  logic [XLEN-1:0]   rt_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              neg_lo_q;
  logic              neg_hi_q;
  logic              div_zero_q;
  logic              done_q;
  logic              accept;
  logic              iter_load;
  logic              iter_step;
  logic              is_div;
  logic              is_signed;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;

  assign accept    = (state_q == ST_IDLE) && bus.start && !bus.flush;
  assign is_div    = op_q inside {MD_DIV, MD_DIVU};
  assign is_signed = op_q inside {MD_MULT, MD_DIV};
  assign a_mag     = (is_signed && rs_q[XLEN-1]) ? -rs_q : rs_q;
  assign b_mag     = (is_signed && rt_q[XLEN-1]) ? -rt_q : rt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_ITER) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  // Flush overrides every non-idle transition and drops the operation.
  always_comb begin
    state_d   = state_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && is_muldiv_op(bus.op)) state_d = ST_PREP;
      ST_PREP: begin
        iter_load = 1'b1;
        state_d   = ST_ITER;
      end
      ST_ITER: begin
        iter_step = 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (iter_load),
    .step   (iter_step),
    .is_div (is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc)
  );

  // Divide by zero bypasses the core result: HI keeps the raw dividend.
  always_comb begin
    prod = neg_lo_q ? -acc : acc;
    if (is_div) begin
      fix_lo = div_zero_q ? '1 :
               (neg_lo_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      fix_hi = div_zero_q ? rs_q :
               (neg_hi_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN]);
    end else begin
      fix_lo = prod[XLEN-1:0];
      fix_hi = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      op_q       <= MD_MULT;
      rs_q       <= '0;
      rt_q       <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (is_muldiv_op(bus.op)) begin
          op_q <= md_op_t'(bus.op);
          rs_q <= bus.rs_val;
          rt_q <= bus.rt_val;
        end else if (bus.op == MD_MTHI) begin
          hi_q <= bus.rs_val;
        end else if (bus.op == MD_MTLO) begin
          lo_q <= bus.rs_val;
        end
      end
      if (state_q == ST_PREP) begin
        neg_lo_q   <= is_signed && (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
        neg_hi_q   <= is_signed && is_div && rs_q[XLEN-1];
        div_zero_q <= (rt_q == '0);
      end
      if (state_q == ST_FIX && !bus.flush) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
